// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one combinational ALU.
// Each operation is latched, executed for one cycle, then held as a registered response until it is accepted.
module alu_arbiter #(
  parameter int NREQ   = 2,
  parameter int WORD_W = 32,
  parameter int OP_W   = 4
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*OP_W-1:0]   req_op,
  input  logic [NREQ*WORD_W-1:0] req_a,
  input  logic [NREQ*WORD_W-1:0] req_b,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [WORD_W-1:0]      rsp_result,
  output logic                   rsp_neg,
  output logic                   rsp_zero,
  output logic                   rsp_over,
  output logic [WORD_W-1:0]      alu_porta,
  output logic [WORD_W-1:0]      alu_portb,
  output logic [OP_W-1:0]        alu_op,
  input  logic [WORD_W-1:0]      alu_outport,
  input  logic                   alu_neg,
  input  logic                   alu_zero,
  input  logic                   alu_over,
  output logic                   busy
);

  // state | meaning
  // IDLE  | arbitrating; req_ready shows the combinational grant
  // EXEC  | operand regs drive the ALU; result captured at the edge
  // RESP  | response held on rsp_valid[win] until rsp_ready[win]

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    win;
  logic [OP_W-1:0]     op_q;
  logic [WORD_W-1:0]   a_q;
  logic [WORD_W-1:0]   b_q;

  logic [NREQ-1:0]     upper_mask;
  logic [NREQ-1:0]     upper_req;
  logic [NREQ-1:0]     grant;
  logic [PTR_W-1:0]    grant_idx;
  logic                grant_any;

  // Requests above the pointer take precedence; if none, wrap to the lowest valid index.
  always_comb begin
    upper_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      upper_mask[i] = (i > int'(ptr));
    end
    upper_req = req_valid & upper_mask;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_idx = PTR_W'(i);
        grant_any = 1'b1;
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (upper_req[i]) begin
        grant_idx = PTR_W'(i);
      end
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Gated by nRST so no grant is offered while the block is held in reset.
  assign req_ready = (state == IDLE && nRST) ? grant : '0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      ptr        <= PTR_W'(NREQ - 1);
      win        <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_neg    <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_over   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            op_q  <= req_op[int'(grant_idx)*OP_W +: OP_W];
            a_q   <= req_a[int'(grant_idx)*WORD_W +: WORD_W];
            b_q   <= req_b[int'(grant_idx)*WORD_W +: WORD_W];
            win   <= grant_idx;
            ptr   <= grant_idx;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_outport;
          rsp_neg    <= alu_neg;
          rsp_zero   <= alu_zero;
          rsp_over   <= alu_over;
          rsp_valid  <= NREQ'(1) << win;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready[win]) begin
            rsp_valid <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign alu_porta = a_q;
  assign alu_portb = b_q;
  assign alu_op    = op_q;
  assign busy      = (state != IDLE);

  a_req_ready_onehot: assert property (@(posedge CLK) disable iff (!nRST) $onehot0(req_ready));
  a_rsp_valid_onehot: assert property (@(posedge CLK) disable iff (!nRST) $onehot0(rsp_valid));
  a_ready_valid_excl: assert property (@(posedge CLK) disable iff (!nRST) !((|req_ready) && (|rsp_valid)));

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter with three requesters: directed scenarios plus randomized traffic,
// checked against a transaction-level reference model and a response scoreboard.
module tb_alu_arbiter;
  localparam int N  = 3;
  localparam int W  = 32;
  localparam int OW = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;

  typedef struct packed { logic [3:0] op; logic [31:0] a; logic [31:0] b; } op_t;
  typedef struct packed { logic [31:0] res; logic n; logic z; logic v; } res_t;
  typedef struct { int idx; res_t r; } exp_t;

  logic CLK = 1'b0;
  logic nRST;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*OW-1:0] req_op;
  logic [N*W-1:0]  req_a, req_b;
  logic [W-1:0]    rsp_result, alu_porta, alu_portb, alu_outport;
  logic            rsp_neg, rsp_zero, rsp_over, alu_neg, alu_zero, alu_over, busy;
  logic [OW-1:0]   alu_op;

  always #5 CLK = ~CLK;

  alu_arbiter #(.NREQ(N), .WORD_W(W), .OP_W(OW)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_neg(rsp_neg), .rsp_zero(rsp_zero), .rsp_over(rsp_over),
    .alu_porta(alu_porta), .alu_portb(alu_portb), .alu_op(alu_op),
    .alu_outport(alu_outport), .alu_neg(alu_neg), .alu_zero(alu_zero), .alu_over(alu_over),
    .busy(busy)
  );

  function automatic res_t alu_f(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    res_t r;
    r.v = 1'b0;
    case (op)
      OP_ADD: begin r.res = a + b; r.v = (a[31] == b[31]) && (r.res[31] != a[31]); end
      OP_SUB: begin r.res = a - b; r.v = (a[31] != b[31]) && (r.res[31] != a[31]); end
      OP_AND: r.res = a & b;
      OP_OR:  r.res = a | b;
      OP_XOR: r.res = a ^ b;
      default: r.res = a;
    endcase
    r.n = r.res[31];
    r.z = (r.res == 32'd0);
    return r;
  endfunction

  res_t alu_r;
  always_comb alu_r = alu_f(alu_op, alu_porta, alu_portb);
  assign alu_outport = alu_r.res;
  assign alu_neg     = alu_r.n;
  assign alu_zero    = alu_r.z;
  assign alu_over    = alu_r.v;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // requester side
  int  budget [N];
  op_t cur [N];
  bit  granted [N];
  int  p_drop = 0;
  int  p_rdy = 100;

  function automatic op_t rand_op();
    op_t o;
    o.op = 4'($urandom_range(0, 4));
    case ($urandom_range(0, 3))
      0: begin o.a = 32'h7FFF_FFFF; o.b = 32'($urandom_range(0, 3)); end
      1: begin o.a = $urandom; o.b = o.a; end
      default: begin o.a = $urandom; o.b = $urandom; end
    endcase
    return o;
  endfunction

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      if (granted[i]) begin
        granted[i] = 1'b0;
        if (budget[i] > 0) budget[i]--;
        cur[i] = rand_op();
      end
      req_valid[i]          = (budget[i] > 0) && (int'($urandom_range(0, 99)) >= p_drop);
      req_op[i*OW +: OW]    = cur[i].op;
      req_a[i*W +: W]       = cur[i].a;
      req_b[i*W +: W]       = cur[i].b;
      rsp_ready[i]          = (int'($urandom_range(0, 99)) < p_rdy);
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    #1;
    apply();
  endtask

  // reference model: one operation at a time, round-robin from the last served requester
  int   m_phase = 0;
  int   m_last = N - 1;
  int   m_win = 0;
  op_t  m_op;
  exp_t exp_q[$];
  int   dlog[$];
  res_t last_res;

  function automatic int pick(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic int oh_idx(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(negedge CLK) begin : model_p
    logic [N-1:0] e_rdy;
    int w;
    exp_t e;
    if (!nRST) begin
      m_phase = 0;
      m_last  = N - 1;
      exp_q.delete();
      chk("rst_req_ready", req_ready, '0);
      chk("rst_rsp_valid", rsp_valid, '0);
    end else begin
      e_rdy = '0;
      w = -1;
      if (m_phase == 0) begin
        w = pick(req_valid, m_last);
        if (w >= 0) e_rdy[w] = 1'b1;
      end
      chk("req_ready", req_ready, e_rdy);
      if ((req_valid & req_ready) != '0) dlog.push_back(oh_idx(req_ready));
      chk("rsp_present", rsp_valid != '0, m_phase == 2);
      chk("busy", busy, m_phase != 0);
      if (m_phase == 1) begin
        chk("alu_porta", alu_porta, m_op.a);
        chk("alu_portb", alu_portb, m_op.b);
        chk("alu_op", alu_op, m_op.op);
      end
      case (m_phase)
        0: if (w >= 0) begin
          m_win = w;
          m_last = w;
          m_op = cur[w];
          e.idx = w;
          e.r = alu_f(cur[w].op, cur[w].a, cur[w].b);
          exp_q.push_back(e);
          granted[w] = 1'b1;
          m_phase = 1;
        end
        1: m_phase = 2;
        default: if (rsp_ready[m_win]) m_phase = 0;
      endcase
    end
  end

  // scoreboard monitor: compares whatever response the DUT presents with the oldest expectation
  always @(negedge CLK) begin : mon_p
    exp_t e;
    if (nRST && rsp_valid != '0) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", rsp_valid, '0);
      else begin
        e = exp_q[0];
        chk("rsp_route", rsp_valid, N'(1) << e.idx);
        chk("rsp_result", rsp_result, e.r.res);
        chk("rsp_flags", {rsp_neg, rsp_zero, rsp_over}, {e.r.n, e.r.z, e.r.v});
        if ((rsp_valid & rsp_ready) != '0) begin
          last_res = {rsp_result, rsp_neg, rsp_zero, rsp_over};
          void'(exp_q.pop_front());
        end
      end
    end
  end

  function automatic bit all_done();
    for (int i = 0; i < N; i++) if (budget[i] > 0) return 1'b0;
    return (m_phase == 0) && (exp_q.size() == 0);
  endfunction

  task automatic run_until_idle(input int maxc, input string name);
    int c;
    c = 0;
    while (!all_done()) begin
      cycle();
      c++;
      if (c > maxc) begin
        chk({name, "_timeout"}, c, maxc);
        break;
      end
    end
  endtask

  task automatic wait_phase(input int ph, input string name);
    int c;
    c = 0;
    while (m_phase != ph) begin
      cycle();
      c++;
      if (c > 10) begin
        chk({name, "_wait"}, m_phase, ph);
        break;
      end
    end
  endtask

  task automatic check_order(input string name, input int first, input int stride_set, input int len);
    // stride_set selects the rotation: 2 -> 0,1 ; 3 -> 0,1,2 ; 4 -> 0,2
    int exp_v;
    chk({name, "_count"}, dlog.size(), len);
    for (int k = 0; k < len && k < dlog.size(); k++) begin
      if (stride_set == 4) exp_v = (k % 2 == 0) ? 0 : 2;
      else exp_v = (first + k) % stride_set;
      chk(name, dlog[k], exp_v);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    nRST = 1'b0;
    for (int i = 0; i < N; i++) begin budget[i] = 0; cur[i] = '0; end
    apply();
    repeat (2) cycle();
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", {rsp_result, rsp_neg, rsp_zero, rsp_over}, '0);
    chk("rst_ports", {alu_porta, alu_portb, alu_op}, '0);
    nRST = 1'b1;

    // single ADD from requester 0
    cur[0] = {OP_ADD, 32'd5, 32'd7};
    budget[0] = 1;
    apply();
    run_until_idle(20, "single");
    chk("add_5_7", last_res, {32'd12, 1'b0, 1'b0, 1'b0});

    // flags
    cur[0] = {OP_ADD, 32'h7FFF_FFFF, 32'd1};
    budget[0] = 1;
    apply();
    run_until_idle(20, "ovf");
    chk("add_ovf", last_res, {32'h8000_0000, 1'b1, 1'b0, 1'b1});
    cur[0] = {OP_SUB, 32'd9, 32'd9};
    budget[0] = 1;
    apply();
    run_until_idle(20, "zero");
    chk("sub_zero", last_res, {32'd0, 1'b0, 1'b1, 1'b0});

    // two-way contention from a fresh pointer
    nRST = 1'b0;
    cycle();
    nRST = 1'b1;
    dlog.delete();
    budget[0] = 2; budget[1] = 2;
    apply();
    run_until_idle(40, "rr2");
    check_order("rr2_grant", 0, 2, 4);

    // response backpressure with a pending request from the other requester
    p_rdy = 0;
    budget[1] = 1;
    apply();
    wait_phase(2, "bp");
    budget[0] = 1;
    apply();
    repeat (5) cycle();
    chk("bp_hold_valid", rsp_valid, 3'b010);
    p_rdy = 100;
    dlog.delete();
    cycle();
    run_until_idle(20, "bp");
    check_order("bp_next_grant", 0, 2, 1);

    // reset while an operation is in EXEC
    cur[0] = {OP_ADD, 32'h1234, 32'h55};
    budget[0] = 1;
    apply();
    wait_phase(1, "rstmid");
    budget[1] = 1;
    apply();
    nRST = 1'b0;
    #1;
    chk("rstmid_ready", req_ready, '0);
    chk("rstmid_valid", rsp_valid, '0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_ports", {alu_porta, alu_portb, alu_op}, '0);
    chk("rstmid_result", {rsp_result, rsp_neg, rsp_zero, rsp_over}, '0);
    apply();
    budget[0] = 1;
    apply();
    cycle();
    cycle();
    dlog.delete();
    nRST = 1'b1;
    run_until_idle(30, "rstmid");
    check_order("rstmid_tie", 0, 2, 2);

    // three-way rotation, then one requester idle
    nRST = 1'b0;
    cycle();
    nRST = 1'b1;
    dlog.delete();
    for (int i = 0; i < N; i++) budget[i] = 3;
    apply();
    run_until_idle(60, "rr3");
    check_order("rr3_grant", 0, 3, 9);
    dlog.delete();
    budget[0] = 2; budget[2] = 2;
    apply();
    run_until_idle(40, "skip");
    check_order("skip_grant", 0, 4, 4);

    // randomized traffic with request drops and response backpressure
    p_drop = 25;
    p_rdy = 50;
    for (int i = 0; i < N; i++) budget[i] = int'($urandom_range(10, 25));
    apply();
    run_until_idle(3000, "random");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
